lc3b_mem_arbiter: RTL and testbench

Memory-side responder for the pipelined LC-3b datapath. It accepts the datapath's instruction-fetch port (port 1, read-only) and data port (port 2, read/write), and serializes them onto one single-ported physical memory with a resp handshake. It returns read data and a one-cycle response pulse to whichever port was served. It sits between `cpu_datapath` and the physical memory or cache.

---
 rtl/lc3b_mem_arbiter_if.sv | 47 ++++
 rtl/lc3b_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_mem_arbiter_if.sv
// Bus bundle between the LC-3b datapath memory ports, the arbiter and the
// single-ported physical memory. The arbiter uses the slave view; the
// master view is the environment (datapath plus physical memory).
interface lc3b_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    // Port 1: instruction fetch (read-only)
    logic [ADDR_WIDTH-1:0] mem_addr1;
    logic                  mem_read1;
    logic [DATA_WIDTH-1:0] mem_rdata1;
    logic                  mem_resp1;

    // Port 2: data (read/write)
    logic [ADDR_WIDTH-1:0] mem_addr2;
    logic                  mem_read2;
    logic                  mem_write2;
    logic [DATA_WIDTH-1:0] mem_wdata2;
    logic [DATA_WIDTH-1:0] mem_rdata2;
    logic                  mem_resp2;

    // Physical memory side
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [DATA_WIDTH-1:0] pmem_wdata;
    logic [DATA_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  mem_addr1, mem_read1,
        output mem_rdata1, mem_resp1,
        input  mem_addr2, mem_read2, mem_write2, mem_wdata2,
        output mem_rdata2, mem_resp2,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_addr1, mem_read1,
        input  mem_rdata1, mem_resp1,
        output mem_addr2, mem_read2, mem_write2, mem_wdata2,
        input  mem_rdata2, mem_resp2,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Two-port to one-port memory arbiter for the pipelined LC-3b datapath.
// Fetch (port 1) and data (port 2) requests are serialized onto a single
// physical memory; ties alternate between ports. Every pmem output comes
// from a register or from the state, so no CPU input reaches pmem
// combinationally.
module lc3b_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    lc3b_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUSY1 = 3'd1,
        S_BUSY2 = 3'd2,
        S_ACK1  = 3'd3,
        S_ACK2  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_served;   // 0: port 1 served last, 1: port 2
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [DATA_WIDTH-1:0] r_rdata2;

    logic w_pend1;
    logic w_pend2;
    logic w_grant2;
    logic w_start;

    assign w_pend1  = bus.mem_read1;
    assign w_pend2  = bus.mem_read2 | bus.mem_write2;
    // Port 2 wins when alone, or on a tie when port 1 was served last.
    assign w_grant2 = w_pend2 & (~w_pend1 | ~r_last_served);
    assign w_start  = (r_state == S_IDLE) & (w_pend1 | w_pend2);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection: arbitrate in IDLE, wait for pmem_resp in BUSY.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = w_grant2 ? S_BUSY2 : S_BUSY1;
                end
            end
            S_BUSY1: if (bus.pmem_resp) w_state_next = S_ACK1;
            S_BUSY2: if (bus.pmem_resp) w_state_next = S_ACK2;
            S_ACK1:  w_state_next = S_IDLE;
            S_ACK2:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobes and responses decoded from the state and latched op only.
    always_comb begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.mem_resp1  = 1'b0;
        bus.mem_resp2  = 1'b0;
        case (r_state)
            S_BUSY1: bus.pmem_read = 1'b1;
            S_BUSY2: begin
                bus.pmem_read  = ~r_is_write;
                bus.pmem_write = r_is_write;
            end
            S_ACK1:  bus.mem_resp1 = 1'b1;
            S_ACK2:  bus.mem_resp2 = 1'b1;
            default: ;
        endcase
    end

    // Request latching on grant, read-data capture and fairness bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served <= 1'b1;
            r_is_write    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata1      <= '0;
            r_rdata2      <= '0;
        end else begin
            if (w_start) begin
                if (w_grant2) begin
                    r_addr     <= bus.mem_addr2;
                    r_wdata    <= bus.mem_wdata2;
                    // read+write together is treated as a write
                    r_is_write <= bus.mem_write2;
                end else begin
                    r_addr     <= bus.mem_addr1;
                    r_is_write <= 1'b0;
                end
            end
            if ((r_state == S_BUSY1) && bus.pmem_resp) begin
                r_rdata1      <= bus.pmem_rdata;
                r_last_served <= 1'b0;
            end
            if ((r_state == S_BUSY2) && bus.pmem_resp) begin
                if (!r_is_write) begin
                    r_rdata2 <= bus.pmem_rdata;
                end
                r_last_served <= 1'b1;
            end
        end
    end

    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.mem_rdata1   = r_rdata1;
    assign bus.mem_rdata2   = r_rdata2;
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Testbench for lc3b_mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbiter and a
// shadow memory holding what the CPU intended to store.
module tb_lc3b_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int INF = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3b_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lc3b_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;

    logic [15:0] phys_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];

    // physical memory responder controls
    int pm_delay = 0;
    bit pm_rand  = 1'b0;
    bit stray    = 1'b0;
    int wait_cnt = 0;

    // transaction-level model
    bit          m_busy;
    int          m_port;
    bit          m_write;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          m_strobe_start, m_resp_due, m_free_at, m_last;
    logic [15:0] exp_rd1, exp_rd2;
    int          grant_q[$];
    int          n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and compare all outputs with the model.
    task automatic cycle_begin();
        bit er, ew, resp_now;
        @(posedge clk);
        #1;
        cyc_n++;
        resp_now = m_busy && (cyc_n == m_resp_due);
        er = m_busy && (cyc_n >= m_strobe_start) && (cyc_n < m_resp_due) && !m_write;
        ew = m_busy && (cyc_n >= m_strobe_start) && (cyc_n < m_resp_due) && m_write;
        if (resp_now && !m_write) begin
            if (m_port == 1) exp_rd1 = m_rdata;
            else             exp_rd2 = m_rdata;
        end
        chk("pmem_read",   bus.pmem_read,  er);
        chk("pmem_write",  bus.pmem_write, ew);
        chk("mem_resp1",   bus.mem_resp1,  resp_now && (m_port == 1));
        chk("mem_resp2",   bus.mem_resp2,  resp_now && (m_port == 2));
        chk("mem_rdata1",  bus.mem_rdata1, exp_rd1);
        chk("mem_rdata2",  bus.mem_rdata2, exp_rd2);
        chk("strobe_excl", bus.pmem_read & bus.pmem_write, 0);
        chk("resp_excl",   bus.mem_resp1 & bus.mem_resp2, 0);
        if (er || ew) chk("pmem_address", bus.pmem_address, m_addr);
        if (ew)       chk("pmem_wdata",   bus.pmem_wdata,   m_wdata);
        if (resp_now) begin
            n_txn++;
            $display("txn %0d: port%0d %s addr=%h data=%h resp_cycle=%0d",
                     n_txn, m_port, m_write ? "WR" : "RD", m_addr,
                     m_write ? m_wdata : m_rdata, cyc_n);
            grant_q.push_back(m_port);
            m_busy = 1'b0;
        end
    endtask

    // Drive pmem for the current cycle and let the model sample requests.
    task automatic cycle_end();
        bit strobe, hit, p1, p2;
        strobe = (bus.pmem_read === 1'b1) || (bus.pmem_write === 1'b1);
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'($urandom);
        if (strobe) begin
            wait_cnt++;
            hit = pm_rand ? ($urandom_range(0, 2) == 0) : (wait_cnt > pm_delay);
            if (hit) begin
                bus.pmem_resp = 1'b1;
                if (bus.pmem_write === 1'b1) phys_mem[bus.pmem_address] = bus.pmem_wdata;
                else                         bus.pmem_rdata = phys_mem[bus.pmem_address];
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
            bus.pmem_resp = stray;
        end

        if (m_busy && (m_resp_due == INF) && (cyc_n >= m_strobe_start) && bus.pmem_resp) begin
            m_resp_due = cyc_n + 1;
            m_free_at  = cyc_n + 2;
            m_last     = m_port;
            if (m_write) ref_mem[m_addr] = m_wdata;
            else         m_rdata = ref_mem[m_addr];
        end

        if (!m_busy && (cyc_n >= m_free_at)) begin
            p1 = bus.mem_read1;
            p2 = bus.mem_read2 || bus.mem_write2;
            if (p1 || p2) begin
                if (p1 && p2) m_port = (m_last == 1) ? 2 : 1;
                else          m_port = p1 ? 1 : 2;
                m_busy         = 1'b1;
                m_strobe_start = cyc_n + 1;
                m_resp_due     = INF;
                if (m_port == 1) begin
                    m_write = 1'b0;
                    m_addr  = bus.mem_addr1;
                end else begin
                    m_write = bus.mem_write2;
                    m_addr  = bus.mem_addr2;
                    m_wdata = bus.mem_wdata2;
                end
            end
        end

        if (rst) begin
            m_busy    = 1'b0;
            m_last    = 2;
            exp_rd1   = '0;
            exp_rd2   = '0;
            m_free_at = cyc_n + 1;
        end
    endtask

    task automatic step();
        cycle_end();
        cycle_begin();
    endtask

    // CPU behaviour: drop a request in its resp cycle, optionally raise a new one.
    task automatic cpu_step(input bit want1, input bit want2);
        int op;
        if (bus.mem_resp1 === 1'b1) begin
            bus.mem_read1 = 1'b0;
        end else if (!bus.mem_read1 && want1) begin
            bus.mem_addr1 = 16'h0300 + 16'($urandom_range(0, 7));
            bus.mem_read1 = 1'b1;
        end
        if (bus.mem_resp2 === 1'b1) begin
            bus.mem_read2  = 1'b0;
            bus.mem_write2 = 1'b0;
        end else if (!(bus.mem_read2 || bus.mem_write2) && want2) begin
            bus.mem_addr2  = 16'h0300 + 16'($urandom_range(0, 7));
            bus.mem_wdata2 = 16'($urandom);
            op = $urandom_range(0, 2);
            bus.mem_read2  = (op != 1);
            bus.mem_write2 = (op != 0);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_busy || bus.mem_read1 || bus.mem_read2 || bus.mem_write2) && (n < budget)) begin
            cpu_step(1'b0, 1'b0);
            step();
            n++;
        end
        chk("drain_timeout", m_busy || bus.mem_read1 || bus.mem_read2 || bus.mem_write2, 0);
    endtask

    initial begin
        int n_wr, n_rsp;
        bit got;

        for (int a = 0; a < 65536; a++) begin
            phys_mem[a] = 16'($urandom);
            ref_mem[a]  = phys_mem[a];
        end
        rst = 1'b1;
        bus.mem_addr1 = '0; bus.mem_read1 = 1'b0;
        bus.mem_addr2 = '0; bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
        bus.mem_wdata2 = '0; bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        m_busy = 1'b0; m_last = 2; exp_rd1 = '0; exp_rd2 = '0;
        m_free_at = 0; m_resp_due = INF; m_strobe_start = INF;
        m_port = 1; m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;

        // reset state
        step();
        chk("rst_pmem_address", bus.pmem_address, 16'h0000);
        chk("rst_pmem_wdata",   bus.pmem_wdata,   16'h0000);
        rst = 1'b0;

        // single fetch, pmem answers in the first strobe cycle
        phys_mem[16'h0040] = 16'h1234; ref_mem[16'h0040] = 16'h1234;
        bus.mem_addr1 = 16'h0040; bus.mem_read1 = 1'b1; pm_delay = 0;
        step();
        chk("t1_strobe", bus.pmem_read, 1);
        chk("t1_addr",   bus.pmem_address, 16'h0040);
        step();
        chk("t1_resp1",  bus.mem_resp1, 1);
        chk("t1_rdata1", bus.mem_rdata1, 16'h1234);
        bus.mem_read1 = 1'b0;
        step();
        chk("t1_idle_strobe", bus.pmem_read, 0);
        chk("t1_idle_resp",   bus.mem_resp1, 0);

        // data read whose address input changes during BUSY2
        phys_mem[16'h0100] = 16'h5A5A; ref_mem[16'h0100] = 16'h5A5A;
        bus.mem_addr2 = 16'h0100; bus.mem_read2 = 1'b1; pm_delay = 2;
        step();
        chk("t5_addr_first", bus.pmem_address, 16'h0100);
        bus.mem_addr2 = 16'h0200;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus.pmem_read) chk("t5_addr_hold", bus.pmem_address, 16'h0100);
            if (bus.mem_resp2) begin
                got = 1'b1;
                bus.mem_read2 = 1'b0;
            end
        end
        chk("t5_resp_seen", got, 1);
        chk("t5_rdata2", bus.mem_rdata2, 16'h5A5A);
        step();

        // data write with four strobe cycles
        bus.mem_addr2 = 16'h2000; bus.mem_wdata2 = 16'hBEEF; bus.mem_write2 = 1'b1; pm_delay = 3;
        n_wr = 0; n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.pmem_write && (bus.pmem_wdata == 16'hBEEF)) n_wr++;
            if (bus.mem_resp2) begin
                n_rsp++;
                bus.mem_write2 = 1'b0;
            end
        end
        chk("t2_strobe_cycles", n_wr, 4);
        chk("t2_resp_pulses",   n_rsp, 1);
        chk("t2_rdata2_kept",   bus.mem_rdata2, 16'h5A5A);
        chk("t2_pmem_written",  phys_mem[16'h2000], 16'hBEEF);

        // reset in the second BUSY1 cycle
        bus.mem_addr1 = 16'h0050; bus.mem_read1 = 1'b1; pm_delay = 10;
        step();
        step();
        chk("t6_busy", bus.pmem_read, 1);
        rst = 1'b1;
        step();
        chk("t6_strobe_off", bus.pmem_read, 0);
        chk("t6_no_resp",    bus.mem_resp1, 0);
        chk("t6_rdata1_clr", bus.mem_rdata1, 16'h0000);
        rst = 1'b0; bus.mem_read1 = 1'b0;
        step();
        chk("t6_no_resp_after", bus.mem_resp1, 0);
        bus.mem_addr1 = 16'h0040; bus.mem_read1 = 1'b1; pm_delay = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus.mem_resp1) begin
                got = 1'b1;
                bus.mem_read1 = 1'b0;
            end
        end
        chk("t6_new_req_done", got, 1);
        chk("t6_new_rdata1",   bus.mem_rdata1, 16'h1234);
        step();

        // contention from reset: grants must alternate starting with port 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_q.delete();
        pm_delay = 0;
        for (int i = 0; i < 16; i++) begin
            cpu_step(1'b1, 1'b1);
            step();
        end
        drain(40);
        chk("t4_grant_count", grant_q.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_grant%0d", i), (grant_q.size() > i) ? grant_q[i] : 0, (i % 2 == 0) ? 1 : 2);
        end

        // read+write together is a write
        bus.mem_addr2 = 16'h3000; bus.mem_wdata2 = 16'hC0DE;
        bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b1; pm_delay = 0;
        step();
        chk("t7_is_write", bus.pmem_write, 1);
        chk("t7_no_read",  bus.pmem_read, 0);
        step();
        chk("t7_resp2", bus.mem_resp2, 1);
        bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
        step();
        chk("t7_mem", phys_mem[16'h3000], 16'hC0DE);

        // stray pmem_resp while idle
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("t7_stray_resp1", bus.mem_resp1, 0);
        chk("t7_stray_resp2", bus.mem_resp2, 0);
        step();
        chk("t7_stray_idle", bus.pmem_read | bus.pmem_write, 0);
        bus.mem_addr2 = 16'h3000; bus.mem_read2 = 1'b1;
        step();
        chk("t7_after_stray_strobe", bus.pmem_read, 1);
        step();
        chk("t7_after_stray_resp2",  bus.mem_resp2, 1);
        chk("t7_after_stray_rdata2", bus.mem_rdata2, 16'hC0DE);
        bus.mem_read2 = 1'b0;
        step();

        // random traffic with random pmem latency
        pm_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cpu_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
        end
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
